ahb_master_arbiter: RTL
=======================

# ahb_master_arbiter

Round-robin AHB bus arbiter that shares the AHB-to-APB bridge slave port between up to NUM_MASTERS AHB masters. It samples bus requests and lock requests, issues a registered one-hot grant, and publishes the address-phase and data-phase master indices for the upstream address/control and write-data multiplexers. Handover happens only on HREADY-qualified cycle boundaries, so the bridge never sees a split transfer.

## Interface
- NUM_MASTERS, 4: number of requesting masters, 2..8.
- MAX_TENURE, 16: beats an owner may hold the bus while others request; used only with the tenure feature.
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  reset, asynchronous and active-high (asserted = 1).
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-sequence request.
- HTRANS  in  2  transfer type on the muxed address bus (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HREADY  in  1  transfer-complete from the bridge (its HREADYout).
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  clog2(NUM_MASTERS)  address-phase owner index, registered.
- HMASTER_D  out  clog2(NUM_MASTERS)  data-phase owner index, registered.
- HMASTLOCK  out  1  current address phase belongs to a locked sequence.

## Operation
- States: ST_PARK (no requests, master 0 parked), ST_OWN (owner holds bus), ST_LOCK (owner in locked sequence).
- All transitions and the counter are qualified by HREADY=1. With HREADY=0, every register holds.
- ST_PARK:
  - No HBUSREQ set: stay in ST_PARK, HGRANT=1 (master 0).
  - Any HBUSREQ set: pick the first requester from rr_ptr upward (wrapping), grant it, go to ST_OWN.
- ST_OWN:
  - If HLOCK[owner]=1 and HTRANS=NONSEQ: go to ST_LOCK.
  - Else if HBUSREQ[owner]=0 (or the tenure has expired and another master is requesting): re-arbitrate.
    - Search starts at owner+1 and wraps.
    - If no requester is found, go to ST_PARK.
  - Else: hold the grant.
- ST_LOCK:
  - Grant is frozen regardless of other requests.
  - HLOCK[owner]=0: return to ST_OWN. Re-arbitration is possible on the next qualified cycle.
- rr_ptr is set to the new owner+1 (mod NUM_MASTERS) on every grant change.
- HMASTER_D takes the value of HMASTER on every HREADY=1 edge.
- HMASTLOCK = 1 while in ST_LOCK.
- Simultaneous owner release and new request: the grant moves in the same edge; there is no dead cycle.
- Owner dropping its request while HREADY=0: ignored until HREADY=1.
- Reset mid-transfer:
  - Outputs return to reset values immediately.
  - A master that loses its grant this way must reissue its transfer.

## Timing
- Reset values:
  - HGRANT=1 (master 0)
  - HMASTER=0, HMASTER_D=0, HMASTLOCK=0
  - state ST_PARK, rr_ptr=0, tenure count=0
- Grant latency: a request sampled on edge N with HREADY=1 gives HGRANT/HMASTER valid after edge N. The master drives NONSEQ in the following cycle.
- HMASTER_D lags HMASTER by exactly one HREADY-qualified edge.
- Outputs are registered only. There are no combinational input-to-output paths.

## Configuration
- ARB_TENURE_LIMIT_EN defined:
  - The tenure counter increments on each HREADY=1 cycle with HTRANS=NONSEQ or SEQ in ST_OWN.
  - It clears on every grant change.
  - When the count reaches MAX_TENURE and another master is requesting, re-arbitration is forced at the next qualified edge.
  - The counter is ignored in ST_LOCK.
- Not defined:
  - No counter is built.
  - The owner keeps the bus for as long as HBUSREQ[owner]=1.

## Structure
- Package ahb_arb_pkg holds:
  - the state enum (ST_PARK/ST_OWN/ST_LOCK)
  - HTRANS encodings
  - the NUM_MASTERS default
  - the index-width function
- Sub-module rr_pick is combinational. It takes a request vector and a start pointer, and returns the first set index at or above the pointer (wrapping) plus a found flag.

## Test plan
- Reset, no requests:
  - HGRANT=0001, HMASTER=0, HMASTLOCK=0, and these values hold for 10 cycles.
- HBUSREQ=0110 from park, HREADY=1:
  - Next edge gives HGRANT=0010.
  - After master 1 drops its request, the next edge gives HGRANT=0100.
  - After master 2 drops its request, the bus parks at 0001.
- Owner 2 drops its request while HREADY=0 for 3 cycles:
  - Grant holds for those 3 cycles.
  - It changes on the first edge with HREADY=1.
  - HMASTER_D follows HMASTER one edge later.
- Master 3 sets HLOCK with NONSEQ while master 0 is requesting:
  - HMASTLOCK=1 and grant stays 1000 until HLOCK[3]=0.
  - Then HGRANT=0001.
- With ARB_TENURE_LIMIT_EN, MAX_TENURE=4, masters 0 and 1 requesting continuously:
  - The grant alternates every 4 SEQ beats.
  - Without the macro, master 0 keeps the bus indefinitely.
- Assert HRESETn mid-burst while owner=2:
  - Outputs return to reset values before the next HCLK edge.

Source files
------------

// File: rtl/ahb_master_arbiter_pkg.sv
// ahb_arb_pkg: shared types and helpers for the AHB master arbiter slice.
// Holds the arbiter state enum, the HTRANS encodings, the default master
// count and the index-width helper used to size HMASTER/HMASTER_D.
package ahb_arb_pkg;

   localparam int unsigned NUM_MASTERS_DEF = 4;

   typedef enum logic [1:0] {
      ST_PARK = 2'd0,
      ST_OWN  = 2'd1,
      ST_LOCK = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   // Width of a master index; never below one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// ahb_master_arbiter_if: request/grant bundle between the AHB masters (plus
// the bridge HREADY) and the arbiter. The master modport is the requesting
// side, the slave modport is the arbiter.
interface ahb_master_arbiter_if
   import ahb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = NUM_MASTERS_DEF
) ();

   localparam int unsigned IDX_W = idx_w(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic                   HREADY;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [IDX_W-1:0]       HMASTER;
   logic [IDX_W-1:0]       HMASTER_D;
   logic                   HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HREADY,
      input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HREADY,
      output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
   );

endinterface

// File: rtl/ahb_master_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set request
// at or above start, wrapping past the top index, plus a found flag.
module rr_pick
   import ahb_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = NUM_MASTERS_DEF,
   localparam int unsigned IDX_W       = idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       start,
   output logic [IDX_W-1:0]       idx,
   output logic                   found
);

   // Scan every position once, starting at start and wrapping.
   always_comb begin : pick
      int unsigned pos;
      logic [IDX_W-1:0] p;
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      p     = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         pos = 32'(start) + i;
         if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
         p = IDX_W'(pos);
         if (!found && req[p]) begin
            found = 1'b1;
            idx   = p;
         end
      end
   end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: round-robin AHB arbiter in front of the AHB-to-APB
// bridge. Registered one-hot grant, address-phase and data-phase owner
// indices; every change is qualified by HREADY so transfers never split.
// Optional ARB_TENURE_LIMIT_EN: caps an owner at MAX_TENURE active beats
// while another master is waiting.
module ahb_master_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = NUM_MASTERS_DEF,
   parameter int unsigned MAX_TENURE  = 16
) (
   input logic                  HCLK,
   input logic                  HRESETn,
   ahb_master_arbiter_if.slave  bus
);

   localparam int unsigned      IDX_W    = idx_w(NUM_MASTERS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_TENURE < 1) begin : g_bad_cfg
      $error("ahb_master_arbiter: unsupported NUM_MASTERS or MAX_TENURE");
   end

   function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] i);
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [NUM_MASTERS-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       master_d_q, master_d_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;

   logic [IDX_W-1:0]       pick_start;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_found;
   logic                   lock_req;
   logic                   release_req;
   logic                   tenure_force;

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_pick (
      .req   (bus.HBUSREQ),
      .start (pick_start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Search origin: rr_ptr when parked, the slot after the owner otherwise.
   always_comb begin
      pick_start  = (state_q == ST_PARK) ? rr_ptr_q : inc_mod(owner_q);
      lock_req    = bus.HLOCK[owner_q] && (bus.HTRANS == HTRANS_NONSEQ);
      release_req = !bus.HBUSREQ[owner_q] || tenure_force;
   end

`ifdef ARB_TENURE_LIMIT_EN
   localparam int unsigned TEN_W = $clog2(MAX_TENURE + 1);

   logic [TEN_W-1:0] tenure_q, tenure_d;
   logic             arb_event;

   // Tenure count: active beats in ST_OWN, saturating, cleared on handover.
   always_comb begin
      tenure_force = (tenure_q == TEN_W'(MAX_TENURE)) &&
                     (|(bus.HBUSREQ & ~grant_q));
      arb_event    = bus.HREADY &&
                     (((state_q == ST_PARK) && pick_found) ||
                      ((state_q == ST_OWN) && !lock_req && release_req));
      tenure_d     = tenure_q;
      if (bus.HREADY) begin
         if (arb_event) begin
            tenure_d = '0;
         end else if ((state_q == ST_OWN) && bus.HTRANS[1] &&
                      (tenure_q != TEN_W'(MAX_TENURE))) begin
            tenure_d = tenure_q + 1'b1;
         end
      end
   end

   // Tenure counter register.
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) tenure_q <= '0;
      else         tenure_q <= tenure_d;
   end
`else
   // Without the tenure limit an owner keeps the bus while it requests.
   always_comb tenure_force = 1'b0;
`endif

   // Arbitration FSM next state; everything holds while HREADY is low.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      master_d_d = master_d_q;
      if (bus.HREADY) begin
         master_d_d = owner_q;
         unique case (state_q)
            ST_PARK: begin
               if (pick_found) begin
                  state_d  = ST_OWN;
                  owner_d  = pick_idx;
                  grant_d  = onehot(pick_idx);
                  rr_ptr_d = inc_mod(pick_idx);
               end
            end
            ST_OWN: begin
               if (lock_req) begin
                  state_d = ST_LOCK;
               end else if (release_req) begin
                  if (pick_found) begin
                     owner_d  = pick_idx;
                     grant_d  = onehot(pick_idx);
                     rr_ptr_d = inc_mod(pick_idx);
                  end else begin
                     state_d  = ST_PARK;
                     owner_d  = '0;
                     grant_d  = onehot('0);
                     rr_ptr_d = inc_mod('0);
                  end
               end
            end
            ST_LOCK: begin
               if (!bus.HLOCK[owner_q]) state_d = ST_OWN;
            end
            default: begin
               state_d = ST_PARK;
               owner_d = '0;
               grant_d = onehot('0);
            end
         endcase
      end
   end

   // State and output registers, asynchronously returned to park.
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         state_q    <= ST_PARK;
         owner_q    <= '0;
         grant_q    <= NUM_MASTERS'(1);
         rr_ptr_q   <= '0;
         master_d_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         master_d_q <= master_d_d;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      bus.HGRANT    = grant_q;
      bus.HMASTER   = owner_q;
      bus.HMASTER_D = master_d_q;
      bus.HMASTLOCK = (state_q == ST_LOCK);
   end

endmodule
